exec_sequencer: RTL and testbench

Multi-cycle execute sequencer for the 16-bit processor. It sits directly upstream of the ALU, drives the ALU's A, B and ALUOp inputs, and consumes the ALU's result, zero and negative outputs. It steps each instruction through FETCH, DECODE, EXECUTE and COMPLETE, reusing the single ALU for three jobs: PC+2, the branch target, and the operation itself. It then hands the latched result, register-write strobe and next PC to writeback.

---
 rtl/exec_seq_pkg.sv | 37 +++
 rtl/exec_seq_decode.sv | 60 ++++++
 rtl/exec_sequencer.sv | 161 ++++++++++++++++
 tb/tb_exec_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_seq_pkg.sv
// Shared encodings for the multi-cycle execute sequencer: FSM states,
// instruction classes, opcode and ALU operation constants.
package exec_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_COMPLETE
    } state_t;

    typedef enum logic [1:0] {
        CLS_RTYPE,
        CLS_ADDI,
        CLS_BRANCH,
        CLS_ILLEGAL
    } instr_class_t;

    localparam logic [3:0] OP_RTYPE_MAX = 4'h6;
    localparam logic [3:0] OP_ADDI      = 4'h8;
    localparam logic [3:0] OP_BEQ       = 4'h9;
    localparam logic [3:0] OP_BLT       = 4'hA;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;

    function automatic logic [15:0] sext4(input logic [3:0] v);
        return {{12{v[3]}}, v};
    endfunction

endpackage

// File: rtl/exec_seq_decode.sv
// Combinational instruction decode: class, ALU operation, B-operand select,
// register-file read addresses, write enable and illegal flag.
module exec_seq_decode
    import exec_seq_pkg::*;
(
    input  logic [15:0] instr,
    output logic [2:0]  alu_op,
    output logic        b_imm,
    output logic [3:0]  rs_addr,
    output logic [3:0]  rt_addr,
    output logic        reg_write,
    output logic        is_branch,
    output logic        is_blt,
    output logic        illegal
);

    logic [3:0]   opcode;
    instr_class_t iclass;

    assign opcode = instr[15:12];
    assign is_blt = (opcode == OP_BLT);

    always_comb begin
        iclass    = CLS_ILLEGAL;
        alu_op    = ALU_ADD;
        b_imm     = 1'b0;
        rs_addr   = instr[7:4];
        rt_addr   = instr[3:0];
        reg_write = 1'b0;
        is_branch = 1'b0;
        illegal   = 1'b0;

        if (opcode <= OP_RTYPE_MAX)
            iclass = CLS_RTYPE;
        else if (opcode == OP_ADDI)
            iclass = CLS_ADDI;
        else if (opcode == OP_BEQ || opcode == OP_BLT)
            iclass = CLS_BRANCH;

        case (iclass)
            CLS_RTYPE: begin
                alu_op    = opcode[2:0];
                reg_write = 1'b1;
            end
            CLS_ADDI: begin
                b_imm     = 1'b1;
                reg_write = 1'b1;
            end
            CLS_BRANCH: begin
                // Branches compare Ra against Rb, which sit one field higher.
                alu_op    = ALU_SUB;
                rs_addr   = instr[11:8];
                rt_addr   = instr[7:4];
                is_branch = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle execute sequencer: FETCH/DECODE/EXECUTE/COMPLETE around one shared ALU.
// Optional sticky illegal-instruction trap enabled by defining EXEC_TRAP_EN.
module exec_sequencer
    import exec_seq_pkg::*;
(
    input  logic        input_CLK,
    input  logic        input_Reset,
    input  logic        input_Start,
    input  logic [15:0] input_Instr,
    input  logic [15:0] input_PC,
    output logic [3:0]  output_RsAddr,
    output logic [3:0]  output_RtAddr,
    input  logic [15:0] input_RsVal,
    input  logic [15:0] input_RtVal,
    output logic [15:0] output_ALU_A,
    output logic [15:0] output_ALU_B,
    output logic [2:0]  output_ALUOp,
    input  logic [15:0] input_ALU_Result,
    input  logic        input_ALU_Zero,
    input  logic        input_ALU_Negative,
    output logic        output_Ready,
    output logic        output_Done,
    output logic [15:0] output_Result,
    output logic [3:0]  output_Rd,
    output logic        output_RegWrite,
    output logic [15:0] output_NextPC,
    output logic        output_BranchTaken
`ifdef EXEC_TRAP_EN
    ,
    output logic        output_Trap
`endif
);

    state_t      state_reg, state_next;
    logic [15:0] instr_reg, pc_reg, pc_plus2_reg, target_reg;
    logic [15:0] rs_val_reg, rt_val_reg, result_reg, next_pc_reg;
    logic [3:0]  rd_reg;
    logic        reg_write_reg, taken_reg;

    logic [2:0]  dec_alu_op;
    logic        dec_b_imm, dec_reg_write, dec_is_branch, dec_is_blt, dec_illegal;
    logic [15:0] imm_ext, branch_offset;
    logic        trapped, ready, accept, branch_taken;

    exec_seq_decode u_decode (
        .instr     (instr_reg),
        .alu_op    (dec_alu_op),
        .b_imm     (dec_b_imm),
        .rs_addr   (output_RsAddr),
        .rt_addr   (output_RtAddr),
        .reg_write (dec_reg_write),
        .is_branch (dec_is_branch),
        .is_blt    (dec_is_blt),
        .illegal   (dec_illegal)
    );

`ifdef EXEC_TRAP_EN
    logic trap_reg;
    assign trapped     = trap_reg;
    assign output_Trap = trap_reg;
`else
    assign trapped = 1'b0;
`endif

    assign imm_ext       = sext4(instr_reg[3:0]);
    assign branch_offset = {imm_ext[14:0], 1'b0};
    assign ready         = (state_reg == ST_IDLE || state_reg == ST_COMPLETE) && !trapped;
    assign accept        = ready && input_Start;
    assign branch_taken  = dec_is_branch && (dec_is_blt ? input_ALU_Negative : input_ALU_Zero);

    always_comb begin
        state_next   = state_reg;
        output_ALU_A = 16'h0000;
        output_ALU_B = 16'h0000;
        output_ALUOp = ALU_ADD;
        case (state_reg)
            ST_IDLE: begin
                if (accept)
                    state_next = ST_FETCH;
            end
            ST_FETCH: begin
                output_ALU_A = pc_reg;
                output_ALU_B = 16'd2;
                state_next   = ST_DECODE;
            end
            ST_DECODE: begin
                output_ALU_A = pc_plus2_reg;
                output_ALU_B = branch_offset;
                state_next   = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                // Illegal opcodes leave the ALU idle and retire as a NOP.
                if (!dec_illegal) begin
                    output_ALU_A = rs_val_reg;
                    output_ALU_B = dec_b_imm ? imm_ext : rt_val_reg;
                    output_ALUOp = dec_alu_op;
                end
                state_next = ST_COMPLETE;
            end
            ST_COMPLETE: begin
                state_next = accept ? ST_FETCH : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge input_CLK) begin
        if (input_Reset) begin
            state_reg     <= ST_IDLE;
            instr_reg     <= 16'h0000;
            pc_reg        <= 16'h0000;
            pc_plus2_reg  <= 16'h0000;
            target_reg    <= 16'h0000;
            rs_val_reg    <= 16'h0000;
            rt_val_reg    <= 16'h0000;
            result_reg    <= 16'h0000;
            next_pc_reg   <= 16'h0000;
            rd_reg        <= 4'h0;
            reg_write_reg <= 1'b0;
            taken_reg     <= 1'b0;
`ifdef EXEC_TRAP_EN
            trap_reg      <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            if (accept) begin
                instr_reg <= input_Instr;
                pc_reg    <= input_PC;
            end
            case (state_reg)
                ST_FETCH: pc_plus2_reg <= input_ALU_Result;
                ST_DECODE: begin
                    target_reg <= input_ALU_Result;
                    rs_val_reg <= input_RsVal;
                    rt_val_reg <= input_RtVal;
                end
                ST_EXECUTE: begin
                    result_reg    <= input_ALU_Result;
                    rd_reg        <= instr_reg[11:8];
                    reg_write_reg <= dec_reg_write;
                    taken_reg     <= branch_taken;
                    next_pc_reg   <= branch_taken ? target_reg : pc_plus2_reg;
`ifdef EXEC_TRAP_EN
                    if (dec_illegal)
                        trap_reg <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    assign output_Ready       = ready;
    assign output_Done        = (state_reg == ST_COMPLETE);
    assign output_RegWrite    = output_Done && reg_write_reg;
    assign output_Result      = result_reg;
    assign output_Rd          = rd_reg;
    assign output_NextPC      = next_pc_reg;
    assign output_BranchTaken = taken_reg;

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: directed vector table, hand-written
// multi-cycle sequences and randomized instructions against a reference model.
`timescale 1ns/1ps
module tb_exec_sequencer;

`ifdef EXEC_TRAP_EN
    localparam bit TRAP_MODE = 1'b1;
`else
    localparam bit TRAP_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] instr, pc, rs_val, rt_val, alu_a, alu_b, alu_res, result, next_pc;
    logic [3:0]  rs_addr, rt_addr, rd;
    logic [2:0]  alu_op;
    logic        zero, neg, ready, done, reg_write, taken;
`ifdef EXEC_TRAP_EN
    logic        trap;
`endif

    logic [15:0] regs [16];
    int checks = 0;
    int errors = 0;
    logic        prev_valid;
    logic [15:0] prev_result, prev_npc;

    always #5 clk = ~clk;

    exec_sequencer dut (
        .input_CLK          (clk),
        .input_Reset        (rst),
        .input_Start        (start),
        .input_Instr        (instr),
        .input_PC           (pc),
        .output_RsAddr      (rs_addr),
        .output_RtAddr      (rt_addr),
        .input_RsVal        (rs_val),
        .input_RtVal        (rt_val),
        .output_ALU_A       (alu_a),
        .output_ALU_B       (alu_b),
        .output_ALUOp       (alu_op),
        .input_ALU_Result   (alu_res),
        .input_ALU_Zero     (zero),
        .input_ALU_Negative (neg),
        .output_Ready       (ready),
        .output_Done        (done),
        .output_Result      (result),
        .output_Rd          (rd),
        .output_RegWrite    (reg_write),
        .output_NextPC      (next_pc),
        .output_BranchTaken (taken)
`ifdef EXEC_TRAP_EN
        ,
        .output_Trap        (trap)
`endif
    );

    // External ALU and register file the sequencer talks to.
    function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a << b[3:0];
            3'd5: return a >> b[3:0];
            3'd6: return a ^ b;
            default: return 16'h0000;
        endcase
    endfunction

    assign alu_res = alu_f(alu_op, alu_a, alu_b);
    assign zero    = (alu_res == 16'h0000);
    assign neg     = alu_res[15];
    assign rs_val  = regs[rs_addr];
    assign rt_val  = regs[rt_addr];

    typedef struct {
        logic [15:0] result;
        logic [3:0]  rd;
        logic        wr;
        logic [15:0] npc;
        logic        taken;
        logic        chk_result;
    } exp_t;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [3:0]  ra;
        logic [15:0] va;
        logic [3:0]  rb;
        logic [15:0] vb;
        logic [15:0] result;
        logic [3:0]  rd;
        logic        wr;
        logic [15:0] npc;
        logic        taken;
    } vec_t;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instruction semantics computed straight from the architectural rules.
    function automatic exp_t model(input logic [15:0] ins, input logic [15:0] p);
        exp_t        e;
        logic [3:0]  op;
        logic [15:0] imm, diff;
        op   = ins[15:12];
        imm  = {{12{ins[3]}}, ins[3:0]};
        e    = '{result: 16'h0, rd: ins[11:8], wr: 1'b0, npc: p + 16'd2, taken: 1'b0, chk_result: 1'b1};
        if (op <= 4'h6) begin
            e.result = alu_f(op[2:0], regs[ins[7:4]], regs[ins[3:0]]);
            e.wr     = 1'b1;
        end else if (op == 4'h8) begin
            e.result = regs[ins[7:4]] + imm;
            e.wr     = 1'b1;
        end else if (op == 4'h9 || op == 4'hA) begin
            diff     = regs[ins[11:8]] - regs[ins[7:4]];
            e.result = diff;
            e.taken  = (op == 4'h9) ? (diff == 16'h0) : diff[15];
            if (e.taken)
                e.npc = p + 16'd2 + imm * 16'd2;
        end else begin
            e.chk_result = 1'b0;
        end
        return e;
    endfunction

    task automatic run_instr(input logic [15:0] ins, input logic [15:0] p, input exp_t e);
        logic [3:0]  op;
        logic [15:0] imm;
        logic        br, legal;
        int          w;
        op    = ins[15:12];
        imm   = {{12{ins[3]}}, ins[3:0]};
        br    = (op == 4'h9) || (op == 4'hA);
        legal = (op <= 4'h6) || (op == 4'h8) || br;
        w     = 0;
        while (!ready && w < 16) begin
            @(negedge clk);
            w++;
        end
        if (!ready) begin
            chk("ready_wait", ready, 16'h1);
            return;
        end
        start = 1'b1;
        instr = ins;
        pc    = p;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k < 4) begin
                chk("mid_done", done, 16'h0);
                chk("mid_ready", ready, 16'h0);
                if (prev_valid) begin
                    chk("hold_result", result, prev_result);
                    chk("hold_npc", next_pc, prev_npc);
                end
            end
            if (k == 1) begin
                chk("fetch_a", alu_a, p);
                chk("fetch_b", alu_b, 16'd2);
                chk("fetch_op", alu_op, 16'd0);
            end
            if (k == 2) begin
                chk("decode_a", alu_a, p + 16'd2);
                chk("decode_b", alu_b, imm << 1);
                if (legal) begin
                    chk("rs_addr", rs_addr, br ? ins[11:8] : ins[7:4]);
                    chk("rt_addr", rt_addr, br ? ins[7:4] : ins[3:0]);
                end
            end
            if (k < 4) begin
                // Start and new words mid-instruction must be ignored.
                start = 1'($urandom_range(0, 1));
                instr = 16'($urandom);
                pc    = 16'($urandom);
            end else begin
                chk("done", done, 16'h1);
                chk("reg_write", reg_write, e.wr);
                chk("next_pc", next_pc, e.npc);
                chk("branch_taken", taken, e.taken);
                chk("ready_complete", ready, legal || !TRAP_MODE);
                if (e.chk_result)
                    chk("result", result, e.result);
                if (e.wr)
                    chk("rd", rd, e.rd);
                start = 1'b0;
            end
        end
        prev_valid  = e.chk_result;
        prev_result = e.result;
        prev_npc    = e.npc;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, ready, 16'h1);
        chk({tag, "_done"}, done, 16'h0);
        chk({tag, "_regwrite"}, reg_write, 16'h0);
        chk({tag, "_result"}, result, 16'h0);
        chk({tag, "_npc"}, next_pc, 16'h0);
        chk({tag, "_rd"}, rd, 16'h0);
        chk({tag, "_taken"}, taken, 16'h0);
        chk({tag, "_alu_a"}, alu_a, 16'h0);
        chk({tag, "_alu_b"}, alu_b, 16'h0);
        chk({tag, "_alu_op"}, alu_op, 16'h0);
        chk({tag, "_rs_addr"}, rs_addr, 16'h0);
        chk({tag, "_rt_addr"}, rt_addr, 16'h0);
        prev_valid  = 1'b1;
        prev_result = 16'h0;
        prev_npc    = 16'h0;
    endtask

    vec_t        vecs [9];
    exp_t        e;
    logic [15:0] b2b_instr [3];
    logic [15:0] b2b_result [3];
    logic [15:0] rnd_instr, rnd_pc;

    initial begin
        vecs[0] = '{16'h0312, 16'h0010, 4'd1, 16'h0005, 4'd2, 16'h0007, 16'h000C, 4'd3, 1'b1, 16'h0012, 1'b0};
        vecs[1] = '{16'h841F, 16'h0100, 4'd1, 16'h0000, 4'd15, 16'h1234, 16'hFFFF, 4'd4, 1'b1, 16'h0102, 1'b0};
        vecs[2] = '{16'h9123, 16'h0020, 4'd1, 16'h0004, 4'd2, 16'h0004, 16'h0000, 4'd0, 1'b0, 16'h0028, 1'b1};
        vecs[3] = '{16'hA12E, 16'h0040, 4'd1, 16'h0001, 4'd2, 16'h0005, 16'hFFFC, 4'd0, 1'b0, 16'h003E, 1'b1};
        vecs[4] = '{16'hA12E, 16'h0040, 4'd1, 16'h0005, 4'd2, 16'h0001, 16'h0004, 4'd0, 1'b0, 16'h0042, 1'b0};
        vecs[5] = '{16'h1512, 16'h0200, 4'd1, 16'h0005, 4'd2, 16'h0007, 16'hFFFE, 4'd5, 1'b1, 16'h0202, 1'b0};
        vecs[6] = '{16'h9123, 16'h0020, 4'd1, 16'h0004, 4'd2, 16'h0005, 16'hFFFF, 4'd0, 1'b0, 16'h0022, 1'b0};
        vecs[7] = '{16'h0312, 16'hFFFE, 4'd1, 16'h8000, 4'd2, 16'h8000, 16'h0000, 4'd3, 1'b1, 16'h0000, 1'b0};
        vecs[8] = '{16'h8217, 16'h0300, 4'd1, 16'h7FFF, 4'd2, 16'h0000, 16'h8006, 4'd2, 1'b1, 16'h0302, 1'b0};

        rst = 1'b1;
        start = 1'b0;
        instr = 16'h0;
        pc = 16'h0;
        for (int i = 0; i < 16; i++) regs[i] = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
`ifdef EXEC_TRAP_EN
        chk("reset_trap", trap, 16'h0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            for (int r = 0; r < 16; r++) regs[r] = 16'($urandom);
            regs[vecs[i].ra] = vecs[i].va;
            regs[vecs[i].rb] = vecs[i].vb;
            e = '{result: vecs[i].result, rd: vecs[i].rd, wr: vecs[i].wr, npc: vecs[i].npc,
                  taken: vecs[i].taken, chk_result: 1'b1};
            run_instr(vecs[i].instr, vecs[i].pc, e);
            if (i % 3 == 2) @(negedge clk);
        end

        // Start held high: three instructions back to back, Done every 4th cycle.
        @(negedge clk);
        regs[1] = 16'h0005;
        regs[2] = 16'h0007;
        b2b_instr[0] = 16'h0312; b2b_result[0] = 16'h000C;
        b2b_instr[1] = 16'h1412; b2b_result[1] = 16'hFFFE;
        b2b_instr[2] = 16'h6512; b2b_result[2] = 16'h0002;
        start = 1'b1;
        instr = b2b_instr[0];
        pc    = 16'h0010;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k % 4 == 0) begin
                chk("b2b_done", done, 16'h1);
                chk("b2b_result", result, b2b_result[k / 4 - 1]);
                chk("b2b_npc", next_pc, 16'h0010 + 16'(2 * (k / 4)));
                if (k < 12) begin
                    instr = b2b_instr[k / 4];
                    pc    = 16'h0010 + 16'(2 * (k / 4));
                end
            end else begin
                chk("b2b_not_done", done, 16'h0);
            end
        end
        start = 1'b0;
        prev_valid  = 1'b1;
        prev_result = 16'h0002;
        prev_npc    = 16'h0016;

        // Reset during EXECUTE aborts the instruction.
        @(negedge clk);
        start = 1'b1;
        instr = 16'h0312;
        pc    = 16'h0080;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("abort");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("abort_no_done", done, 16'h0);
        end

        // Randomized instructions against the reference model.
        for (int n = 0; n < 60; n++) begin
            for (int r = 0; r < 16; r++) regs[r] = 16'($urandom);
            rnd_instr = 16'($urandom);
            if (TRAP_MODE && (rnd_instr[15:12] == 4'h7 || rnd_instr[15:12] > 4'hA))
                rnd_instr[15:12] = 4'($urandom_range(0, 6));
            rnd_pc = 16'($urandom);
            e = model(rnd_instr, rnd_pc);
            run_instr(rnd_instr, rnd_pc, e);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Illegal opcodes.
        e = model(16'hF000, 16'h0050);
        run_instr(16'hF000, 16'h0050, e);
`ifdef EXEC_TRAP_EN
        chk("trap_set", trap, 16'h1);
        start = 1'b1;
        instr = 16'h0312;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("trap_no_done", done, 16'h0);
            chk("trap_not_ready", ready, 16'h0);
        end
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("trap_cleared", trap, 16'h0);
        chk("trap_ready", ready, 16'h1);
        prev_valid = 1'b0;
        regs[1] = 16'h0005;
        regs[2] = 16'h0007;
        e = model(16'h0312, 16'h0010);
        run_instr(16'h0312, 16'h0010, e);
`else
        e = model(16'h7123, 16'hFFFF);
        run_instr(16'h7123, 16'hFFFF, e);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
